// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Sequences one EX/MEM load/store over a req/ack data-memory port,
//            stalls upstream until completion, flags misalignment and timeout.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int n       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset_in,
    input  logic         MemRead_in,
    input  logic         MemWrite_in,
    input  logic [n-1:0] ALU_Result_in,
    input  logic [n-1:0] RT_data_in,
    input  logic         mem_ack,
    input  logic [n-1:0] mem_rdata,
    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    output logic         stall,
    output logic [n-1:0] load_data,
    output logic         load_valid,
    output logic         err_valid,
    output logic [1:0]   err_code
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_ERR_NONE  = 2'b00;
    localparam logic [1:0] c_ERR_ALIGN = 2'b01;
    localparam logic [1:0] c_ERR_TMO   = 2'b10;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          req_q,    req_d;
    logic          we_q,     we_d;
    logic [n-1:0]  addr_q,   addr_d;
    logic [n-1:0]  wdata_q,  wdata_d;
    logic [n-1:0]  ldata_q,  ldata_d;
    logic [1:0]    err_q,    err_d;

    logic w_access;
    logic w_aligned;
    logic w_cnt_last;
    logic w_in_idle;
    logic w_in_req;
    logic w_in_done;

    assign w_access   = MemRead_in | MemWrite_in;
    assign w_aligned  = (ALU_Result_in[1:0] == 2'b00);
    assign w_cnt_last = (cnt_q == c_CNT_LAST);
    assign w_in_idle  = (state_q == c_IDLE);
    assign w_in_req   = (state_q == c_REQ);
    assign w_in_done  = (state_q == c_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ldata_d = ldata_q;
        err_d   = err_q;

        case (state_q)
            c_IDLE: begin
                if (w_access) begin
                    if (w_aligned) begin
                        // A simultaneous read+write flag resolves to a write.
                        addr_d  = ALU_Result_in;
                        wdata_d = RT_data_in;
                        we_d    = MemWrite_in;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        err_d   = c_ERR_NONE;
                        state_d = c_REQ;
                    end else begin
                        err_d   = c_ERR_ALIGN;
                        ldata_d = '0;
                        state_d = c_DONE;
                    end
                end
            end

            c_REQ: begin
                // Ack on the final counted cycle still completes successfully.
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = c_DONE;
                    if (!we_q) begin
                        ldata_d = mem_rdata;
                    end
                end else if (w_cnt_last) begin
                    req_d   = 1'b0;
                    err_d   = c_ERR_TMO;
                    ldata_d = '0;
                    state_d = c_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            c_DONE: begin
                // Error code lives only for the DONE cycle.
                err_d   = c_ERR_NONE;
                state_d = c_IDLE;
            end

            default: begin
                req_d   = 1'b0;
                err_d   = c_ERR_NONE;
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_in) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            err_q   <= c_ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign load_data  = ldata_q;
    assign err_code   = err_q;
    assign err_valid  = w_in_done & (err_q != c_ERR_NONE);
    assign load_valid = w_in_done & (err_q == c_ERR_NONE) & ~we_q;

    // Reset gating keeps the pipeline free to flush while held in reset.
    assign stall = reset_in & ((w_in_idle & w_access) | w_in_req);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Randomized transaction-level checking of mem_access_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int N  = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_in;
    logic          MemRead_in;
    logic          MemWrite_in;
    logic [N-1:0]  ALU_Result_in;
    logic [N-1:0]  RT_data_in;
    logic          mem_ack;
    logic [N-1:0]  mem_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [N-1:0]  mem_addr;
    logic [N-1:0]  mem_wdata;
    logic          stall;
    logic [N-1:0]  load_data;
    logic          load_valid;
    logic          err_valid;
    logic [1:0]    err_code;

    int n_vec = 0;
    int n_err = 0;
    logic [N-1:0] ld_model = '0;

    mem_access_ctrl #(.n(N), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset_in      (reset_in),
        .MemRead_in    (MemRead_in),
        .MemWrite_in   (MemWrite_in),
        .ALU_Result_in (ALU_Result_in),
        .RT_data_in    (RT_data_in),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .stall         (stall),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .err_valid     (err_valid),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_idle(input bit stray);
        MemRead_in    = 1'b0;
        MemWrite_in   = 1'b0;
        ALU_Result_in = $urandom;
        RT_data_in    = $urandom;
        mem_ack       = stray;
        mem_rdata     = $urandom;
    endtask

    // One EX/MEM access: cycle 0 is the first cycle it is visible in IDLE.
    // k is the cycle carrying ack; k > TO means the memory never answers.
    task automatic run_access(input bit rd, input bit wr, input logic [N-1:0] addr,
                              input logic [N-1:0] wd, input logic [N-1:0] rdv,
                              input int k, input bit stray, input int gap);
        bit mis;
        bit tmo;
        int done_cyc;
        logic [1:0] err_exp;
        mis      = (addr[1:0] != 2'b00);
        tmo      = !mis && (k > TO);
        done_cyc = mis ? 1 : (tmo ? TO + 1 : k + 1);
        err_exp  = mis ? 2'b01 : (tmo ? 2'b10 : 2'b00);
        for (int c = 0; c <= done_cyc; c++) begin
            @(posedge clk); #1;
            MemRead_in    = rd;
            MemWrite_in   = wr;
            ALU_Result_in = addr;
            RT_data_in    = wd;
            mem_ack       = (c == 0 || c == done_cyc) ? stray : (c == k);
            mem_rdata     = (c == k) ? rdv : $urandom;
            @(negedge clk);
            chk_eq("stall", stall, c < done_cyc);
            chk_eq("mem_req", mem_req, !mis && c >= 1 && c < done_cyc);
            if (!mis && c >= 1 && c < done_cyc) begin
                chk_eq("mem_we", mem_we, wr);
                chk_eq("mem_addr", mem_addr, addr);
                chk_eq("mem_wdata", mem_wdata, wd);
            end
            if (c == done_cyc) begin
                if (err_exp != 2'b00) ld_model = '0;
                else if (!wr)         ld_model = rdv;
                chk_eq("load_valid", load_valid, err_exp == 2'b00 && !wr);
                chk_eq("err_valid", err_valid, err_exp != 2'b00);
                chk_eq("err_code", err_code, err_exp);
            end else begin
                chk_eq("load_valid_idle", load_valid, 1'b0);
                chk_eq("err_valid_idle", err_valid, 1'b0);
            end
            chk_eq("load_data", load_data, ld_model);
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            drive_idle($urandom_range(0, 1));
            @(negedge clk);
            chk_eq("gap_stall", stall, 1'b0);
            chk_eq("gap_req", mem_req, 1'b0);
            chk_eq("gap_err_valid", err_valid, 1'b0);
            chk_eq("gap_load_data", load_data, ld_model);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_req"}, mem_req, 1'b0);
        chk_eq({tag, "_stall"}, stall, 1'b0);
        chk_eq({tag, "_we"}, mem_we, 1'b0);
        chk_eq({tag, "_addr"}, mem_addr, '0);
        chk_eq({tag, "_wdata"}, mem_wdata, '0);
        chk_eq({tag, "_ldata"}, load_data, '0);
        chk_eq({tag, "_lvalid"}, load_valid, 1'b0);
        chk_eq({tag, "_evalid"}, err_valid, 1'b0);
        chk_eq({tag, "_ecode"}, err_code, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with an access pending: stall must stay low while in reset.
        reset_in = 1'b0;
        drive_idle(1'b0);
        MemRead_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset_in = 1'b1;
        drive_idle(1'b0);
        @(negedge clk);
        ld_model = '0;

        run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 1);
        run_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0, 1, 1'b0, 1);
        run_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 0);
        run_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 32'h0, 1, 1'b0, 1);
        run_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h5555_AAAA, TO + 1, 1'b0, 1);
        run_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'hA5A5_5A5A, TO, 1'b0, 1);
        run_access(1'b1, 1'b1, 32'h0000_0048, 32'h0BAD_CAFE, 32'h0, 2, 1'b1, 0);
        run_access(1'b1, 1'b0, 32'h0000_004C, 32'h0, 32'h1111_2222, 2, 1'b1, 0);

        // Reset lands during REQ: no DONE, everything cleared.
        @(posedge clk); #1;
        drive_idle(1'b0);
        MemRead_in    = 1'b1;
        ALU_Result_in = 32'h0000_0050;
        @(negedge clk);
        chk_eq("rst_c0_stall", stall, 1'b1);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk_eq("rst_c1_req", mem_req, 1'b1);
        @(posedge clk); #1;
        reset_in = 1'b0;
        @(negedge clk);
        chk_eq("rst_c2_stall", stall, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_all_zero("midreq");
        ld_model = '0;
        @(posedge clk); #1;
        reset_in = 1'b1;
        drive_idle(1'b0);
        @(negedge clk);
        chk_eq("post_rst_req", mem_req, 1'b0);
        run_access(1'b1, 1'b0, 32'h0000_0054, 32'h0, 32'h7777_8888, 2, 1'b0, 1);

        for (int t = 0; t < 80; t++) begin
            int op;
            logic [N-1:0] a;
            op = $urandom_range(0, 2);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_access(op != 1, op != 0, a, $urandom, $urandom,
                       $urandom_range(1, TO + 2), $urandom_range(0, 1),
                       $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
